// File: rtl/l5_accum.sv
// l5_accum: layer-5 partial-sum accumulator, bias add, rescale and saturation.
// Takes NUM_GROUPS partial sums per neuron and produces one 18-bit activation
// per neuron. It also drives the neuron/group indices that address the
// upstream weight/bias ROM and input buffer.
// Optional build macro RELU_EN: when defined, negative results clamp to 0
// (hidden layers). When undefined, the signed result passes through to the
// output (final-layer logits).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs hold last result
// ACCUM  | accepting partial sums for neuron_idx, group_idx counts them
// FINISH | bias add, rescale, saturate; emit dout for neuron_idx
// DONE   | one-cycle done pulse after the final neuron
module l5_accum #(
  parameter int NUM_GROUPS  = 4,
  parameter int NUM_NEURONS = 10,
  parameter int ACC_W       = 42,
  parameter int SHIFT       = 8,
  parameter int BIAS_SHIFT  = 8,
  localparam int NI_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int GI_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    psum_valid,
  input  logic signed [35:0]      psum,
  output logic                    psum_ready,
  input  logic signed [8:0]       bias,
  output logic [NI_W-1:0]         neuron_idx,
  output logic [GI_W-1:0]         group_idx,
  output logic                    busy,
  output logic signed [17:0]      dout,
  output logic [NI_W-1:0]         out_idx,
  output logic                    out_valid,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [NI_W-1:0] LAST_NEURON = NI_W'(NUM_NEURONS - 1);
  localparam logic [GI_W-1:0] LAST_GROUP  = GI_W'(NUM_GROUPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(131072);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [NI_W-1:0]          neuron_idx_q, neuron_idx_d;
  logic [GI_W-1:0]          group_idx_q, group_idx_d;
  logic signed [17:0]       dout_q, dout_d;
  logic [NI_W-1:0]          out_idx_q, out_idx_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  t_sum;
  logic signed [ACC_W-1:0]  r_shift;
  logic signed [17:0]       r_sat;

  // Datapath: sign-extend inputs, bias add, arithmetic rescale, clamp to 18 bits.
  always_comb begin
    psum_ext = {{(ACC_W-36){psum[35]}}, psum};
    bias_ext = {{(ACC_W-9){bias[8]}}, bias};
    t_sum    = acc_q + (bias_ext <<< BIAS_SHIFT);
    r_shift  = t_sum >>> SHIFT;
    r_sat    = r_shift[17:0];
`ifdef RELU_EN
    if (r_shift < 0) begin
      r_sat = '0;
    end else if (r_shift > SAT_MAX) begin
      r_sat = 18'sh1FFFF;
    end
`else
    if (r_shift > SAT_MAX) begin
      r_sat = 18'sh1FFFF;
    end else if (r_shift < SAT_MIN) begin
      r_sat = 18'sh20000;
    end
`endif
  end

  // Next-state and register updates for the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    neuron_idx_d = neuron_idx_q;
    group_idx_d  = group_idx_q;
    dout_d       = dout_q;
    out_idx_d    = out_idx_q;
    out_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d        = '0;
          neuron_idx_d = '0;
          group_idx_d  = '0;
          state_d      = ACCUM;
        end
      end
      ACCUM: begin
        if (psum_valid) begin
          acc_d = acc_q + psum_ext;
          if (group_idx_q == LAST_GROUP) begin
            group_idx_d = '0;
            state_d     = FINISH;
          end else begin
            group_idx_d = group_idx_q + GI_W'(1);
          end
        end
      end
      FINISH: begin
        dout_d      = r_sat;
        out_idx_d   = neuron_idx_q;
        out_valid_d = 1'b1;
        if (neuron_idx_q == LAST_NEURON) begin
          state_d = DONE;
        end else begin
          neuron_idx_d = neuron_idx_q + NI_W'(1);
          acc_d        = '0;
          state_d      = ACCUM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any pass in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      neuron_idx_q <= '0;
      group_idx_q  <= '0;
      dout_q       <= '0;
      out_idx_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      neuron_idx_q <= neuron_idx_d;
      group_idx_q  <= group_idx_d;
      dout_q       <= dout_d;
      out_idx_q    <= out_idx_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    psum_ready = (state_q == ACCUM);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

  assign neuron_idx = neuron_idx_q;
  assign group_idx  = group_idx_q;
  assign dout       = dout_q;
  assign out_idx    = out_idx_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_l5_accum.sv
// Testbench for l5_accum: directed and randomized layer passes checked
// against an arithmetic reference of sum, bias, floor-divide and clamp.
module tb_l5_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               psum_valid;
  logic signed [35:0] psum;
  logic               psum_ready;
  logic signed [8:0]  bias;
  logic [3:0]         neuron_idx;
  logic [1:0]         group_idx;
  logic               busy;
  logic signed [17:0] dout;
  logic [3:0]         out_idx;
  logic               out_valid;
  logic               done;

  logic signed [8:0]  bias_tab [10];
  longint             psum_tab [10][4];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign bias = bias_tab[neuron_idx];

  l5_accum dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .psum_valid (psum_valid),
    .psum       (psum),
    .psum_ready (psum_ready),
    .bias       (bias),
    .neuron_idx (neuron_idx),
    .group_idx  (group_idx),
    .busy       (busy),
    .dout       (dout),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .done       (done)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor((sum of psums + bias*256) / 256), optional ReLU, clamp.
  function automatic longint ref_dout(input int n);
    longint t;
    longint r;
    t = longint'(bias_tab[n]) * 256;
    for (int g = 0; g < 4; g++) t += psum_tab[n][g];
    r = t / 256;
    if (t < 0 && (t % 256) != 0) r -= 1;
`ifdef RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  function automatic longint rand_psum();
    logic [63:0]        w;
    logic signed [35:0] x;
    case ($urandom_range(0, 2))
      0: return longint'($urandom_range(0, 262143)) - 131072;
      1: return longint'(int'($urandom));
      default: begin
        w = {$urandom, $urandom};
        x = w[35:0];
        return longint'(x);
      end
    endcase
  endfunction

  function automatic logic signed [35:0] garbage();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[35:0];
  endfunction

  task automatic fill_random(input int first);
    for (int n = first; n < 10; n++) begin
      bias_tab[n] = 9'(int'($urandom_range(0, 511)) - 256);
      for (int g = 0; g < 4; g++) psum_tab[n][g] = rand_psum();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, psum_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nidx"}, neuron_idx, 0);
    chk({tag, "_gidx"}, group_idx, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_oidx"}, out_idx, 0);
    chk({tag, "_ovalid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: valid always high (cycle schedule checked), 1: toggling, 2: random.
  task automatic run_pass(input int mode, input int glitch_cyc, input int rst_neuron);
    longint exp_q[$];
    int     idx_q[$];
    int     n_fed = 0;
    int     g_fed = 0;
    bit     got_done = 0;
    bit     acc_now;
    for (int n = 0; n < 10; n++) begin
      exp_q.push_back(ref_dout(n));
      idx_q.push_back(n);
    end
    start = 1'b1;
    psum_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_nidx", neuron_idx, 0);
    chk("start_gidx", group_idx, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (mode == 0) begin
        chk("sched_ready", psum_ready, (cyc < 49 && cyc % 5 != 4) ? 1 : 0);
        chk("sched_ovalid", out_valid, (cyc >= 5 && cyc % 5 == 0) ? 1 : 0);
        chk("sched_done", done, (cyc == 50) ? 1 : 0);
        chk("sched_busy", busy, 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("dout", dout, exp_q.pop_front());
          chk("out_idx", out_idx, idx_q.pop_front());
        end
      end
      if (done) begin
        chk("done_after_all", exp_q.size(), 0);
        got_done = 1;
        break;
      end
      if (rst_neuron >= 0 && n_fed == rst_neuron && g_fed == 2) begin
        psum_valid = 1'b1;
        psum = garbage();
        #2 rst = 1'b1;
        #1 check_all_zero("rst_async");
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("post_rst_ovalid", out_valid, 0);
          chk("post_rst_done", done, 0);
          chk("post_rst_busy", busy, 0);
        end
        psum_valid = 1'b0;
        return;
      end
      start = (cyc == glitch_cyc) ? 1'b1 : 1'b0;
      case (mode)
        0: psum_valid = 1'b1;
        1: psum_valid = (cyc % 2 == 0);
        default: psum_valid = 1'($urandom_range(0, 1));
      endcase
      if (psum_ready && n_fed < 10) psum = 36'(psum_tab[n_fed][g_fed]);
      else psum = garbage();
      acc_now = psum_valid && psum_ready;
      if (acc_now) begin
        chk("acc_nidx", neuron_idx, n_fed);
        chk("acc_gidx", group_idx, g_fed);
      end
      tick();
      if (acc_now) begin
        g_fed++;
        if (g_fed == 4) begin
          g_fed = 0;
          n_fed++;
        end
      end
    end
    start = 1'b0;
    if (!got_done) chk("timeout_done", 0, 1);
    psum_valid = 1'b1;
    psum = garbage();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ovalid", out_valid, 0);
    chk("idle_ready", psum_ready, 0);
    psum_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    psum_valid = 1'b0;
    psum = '0;
    for (int n = 0; n < 10; n++) bias_tab[n] = '0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("after_reset");

    // 256 x4, bias 0 -> 4 per neuron; continuous valid checks the schedule.
    for (int n = 0; n < 10; n++) begin
      bias_tab[n] = '0;
      for (int g = 0; g < 4; g++) psum_tab[n][g] = 256;
    end
    run_pass(0, -1, -1);

    // Directed rounding/saturation cases, toggled valid and ignored start.
    fill_random(4);
    psum_tab[0][0] = 256; psum_tab[0][1] = -512; psum_tab[0][2] = 1024; psum_tab[0][3] = 0;
    bias_tab[0] = 9'sd3;
    psum_tab[1][0] = 256; psum_tab[1][1] = -512; psum_tab[1][2] = 1024; psum_tab[1][3] = 0;
    bias_tab[1] = -9'sd4;
    for (int g = 0; g < 4; g++) begin
      psum_tab[2][g] = 64'sd1 <<< 34;
      psum_tab[3][g] = -(64'sd1 <<< 34);
    end
    bias_tab[2] = '0;
    bias_tab[3] = '0;
    run_pass(1, 7, -1);

    // Random data, random valid.
    fill_random(0);
    run_pass(2, 20, -1);

    // Reset during neuron 3, then a clean restart.
    fill_random(0);
    run_pass(0, -1, 3);
    fill_random(0);
    run_pass(2, -1, -1);

    // Random data with continuous valid and schedule checks.
    fill_random(0);
    run_pass(0, 30, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
